// File: rtl/sparc_mem_pkg.sv
// SPARC V8 load/store op3 codes, access-size decode and responder FSM encoding.
// Shared between the RAM responder and the control unit.
package sparc_mem_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_e;

    typedef struct packed {
        logic      valid;
        logic      store;
        logic      sign_ext;
        mem_size_e size;
    } op_dec_t;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_ACK = 2'd2} mfc_state_e;

    function automatic op_dec_t decode_op3(input logic [5:0] op3);
        op_dec_t d;
        d = '{valid: 1'b1, store: 1'b0, sign_ext: 1'b0, size: SZ_WORD};
        case (op3)
            OP_LD:   d.size = SZ_WORD;
            OP_LDUB: d.size = SZ_BYTE;
            OP_LDUH: d.size = SZ_HALF;
            OP_LDD:  d.size = SZ_DWORD;
            OP_ST:   d.store = 1'b1;
            OP_STB:  begin d.store = 1'b1; d.size = SZ_BYTE; end
            OP_STH:  begin d.store = 1'b1; d.size = SZ_HALF; end
            OP_STD:  begin d.store = 1'b1; d.size = SZ_DWORD; end
            OP_LDSB: begin d.sign_ext = 1'b1; d.size = SZ_BYTE; end
            OP_LDSH: begin d.sign_ext = 1'b1; d.size = SZ_HALF; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Undefined opcodes are folded into the misalign abort path.
    function automatic logic misaligned(input op_dec_t d, input logic [2:0] a);
        logic m;
        case (d.size)
            SZ_HALF:  m = a[0];
            SZ_WORD:  m = |a[1:0];
            SZ_DWORD: m = |a;
            default:  m = 1'b0;
        endcase
        return m | ~d.valid;
    endfunction

endpackage

// File: rtl/ram_mfc_responder_if.sv
// RAM request / MFC handshake between control unit (master) and memory (slave).
interface ram_mfc_responder_if;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        MisalignErr;

    modport master (
        output RAM_enable, RAM_OpCode, Address, DataIn,
        input  DataOut, MFC, MisalignErr
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, Address, DataIn,
        output DataOut, MFC, MisalignErr
    );
endinterface

// File: rtl/ram_load_align.sv
// Extracts and extends the addressed byte/half/word from a big-endian word and
// flags misaligned or undefined accesses (for stores as well as loads).
module ram_load_align
    import sparc_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  addr,
    input  logic [5:0]  op3,
    output logic [31:0] data,
    output logic        misalign
);
    op_dec_t     dec;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        dec      = decode_op3(op3);
        misalign = misaligned(dec, addr);
        case (addr[1:0])
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr[1] ? word[15:0] : word[31:16];
        data = '0;
        if (!misalign && !dec.store) begin
            case (dec.size)
                SZ_BYTE: data = {{24{dec.sign_ext & byte_sel[7]}}, byte_sel};
                SZ_HALF: data = {{16{dec.sign_ext & half_sel[15]}}, half_sel};
                default: data = word;
            endcase
        end
    end
endmodule

// File: rtl/ram_mfc_responder.sv
// Wait-state RAM responder with MFC handshake over a big-endian byte array.
module ram_mfc_responder
    import sparc_mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = "ram_init.txt"
) (
    input  logic                Clk,
    input  logic                Clr,
    ram_mfc_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    mfc_state_e            state, state_next;
    logic [3:0]            cnt;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic                  accept, access;

    logic [5:0]            op_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [31:0]           din_a;
    logic [31:0]           word;
    logic [31:0]           ld_data;
    logic                  misalign;
    op_dec_t               dec;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  unused_addr;

    assign unused_addr = ^bus.Address[31:ADDR_WIDTH];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            ST_IDLE: if (bus.RAM_enable) begin
                accept = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    access     = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: if (cnt == 4'd0) begin
                access     = 1'b1;
                state_next = ST_ACK;
            end
            ST_ACK:  if (!bus.RAM_enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // With zero wait the access happens on the accepting edge, so use live inputs.
    always_comb begin
        op_a   = (state == ST_IDLE) ? bus.RAM_OpCode : op_q;
        addr_a = (state == ST_IDLE) ? bus.Address[ADDR_WIDTH-1:0] : addr_q;
        din_a  = (state == ST_IDLE) ? bus.DataIn : din_q;
        word   = {mem[{addr_a[ADDR_WIDTH-1:2], 2'd0}], mem[{addr_a[ADDR_WIDTH-1:2], 2'd1}],
                  mem[{addr_a[ADDR_WIDTH-1:2], 2'd2}], mem[{addr_a[ADDR_WIDTH-1:2], 2'd3}]};
    end

    ram_load_align u_align (
        .word     (word),
        .addr     (addr_a[2:0]),
        .op3      (op_a),
        .data     (ld_data),
        .misalign (misalign)
    );

    // be[i] enables byte offset i within the word (offset 0 = bits 31:24).
    always_comb begin
        dec   = decode_op3(op_a);
        be    = 4'b0000;
        wdata = din_a;
        if (dec.store && !misalign) begin
            case (dec.size)
                SZ_BYTE: begin be = 4'b0001 << addr_a[1:0]; wdata = {4{din_a[7:0]}}; end
                SZ_HALF: begin be = addr_a[1] ? 4'b1100 : 4'b0011; wdata = {2{din_a[15:0]}}; end
                default: be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (access && Clr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[{addr_a[ADDR_WIDTH-1:2], 2'(i)}] <= wdata[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt    <= 4'(WAIT_CYCLES);
                op_q   <= bus.RAM_OpCode;
                addr_q <= bus.Address[ADDR_WIDTH-1:0];
                din_q  <= bus.DataIn;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                data_q <= ld_data;
                err_q  <= misalign;
            end
        end
    end

    assign bus.DataOut     = data_q;
    assign bus.MisalignErr = err_q;
    assign bus.MFC         = (state == ST_ACK);
endmodule

// File: tb/tb_ram_mfc_responder.sv
// Randomized scoreboard bench for ram_mfc_responder against a byte-array reference model.
module tb_ram_mfc_responder;
    import sparc_mem_pkg::*;

    localparam int WAIT = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    logic Clk = 1'b0;
    logic Clr = 1'b0;
    always #5 Clk = ~Clk;

    ram_mfc_responder_if bus ();

    ram_mfc_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(WAIT), .INIT_FILE("ram_init.txt")) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [7:0]  ref_mem [512];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = '0;
    logic        last_err  = 1'b0;
    logic        mfc_prev  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endfunction

    // Reference: apply the access rules directly to a flat byte array.
    function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                  input logic [31:0] din, output exp_t e);
        int a, n;
        bit st, sx, ok;
        logic [31:0] v;
        a = int'(addr[8:0]);
        n = 0; st = 0; sx = 0;
        case (int'(op))
            0, 3:  n = 4;
            1:     n = 1;
            2:     n = 2;
            4, 7:  begin n = 4; st = 1; end
            5:     begin n = 1; st = 1; end
            6:     begin n = 2; st = 1; end
            9:     begin n = 1; sx = 1; end
            10:    begin n = 2; sx = 1; end
            default: n = 0;
        endcase
        ok = (n != 0) && (a % n == 0) && !((op == 6'd3 || op == 6'd7) && (a % 8 != 0));
        e.err = !ok;
        e.data = '0;
        e.chk_data = !ok || !st;
        if (ok && st)
            for (int i = 0; i < n; i++) ref_mem[a+i] = din[8*(n-1-i) +: 8];
        if (ok && !st) begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a+i]);
            if (sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.data = v;
        end
    endfunction

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (bus.MFC && !mfc_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_mfc", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                last_data = bus.DataOut;
                last_err  = bus.MisalignErr;
                chk("misalign_err", 32'(bus.MisalignErr), 32'(e.err));
                if (e.chk_data) chk("data_out", bus.DataOut, e.data);
            end
        end
        mfc_prev <= bus.MFC;
    end

    task automatic req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] din,
                       input int hold, input bit rst_in_ack);
        exp_t e;
        int n;
        model(op, addr, din, e);
        sb.push_back(e);
        bus.RAM_OpCode = op;
        bus.Address    = addr;
        bus.DataIn     = din;
        bus.RAM_enable = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            // Request is latched; later input changes must be ignored.
            if (n == 1) begin
                bus.RAM_OpCode = 6'($urandom);
                bus.Address    = $urandom;
                bus.DataIn     = $urandom;
            end
        end while (!bus.MFC && n < 40);
        chk("mfc_latency", 32'(n), 32'(WAIT + 2));
        if (rst_in_ack) begin
            Clr = 1'b0;
            #1;
            chk("ack_rst_mfc", 32'(bus.MFC), 32'd0);
            chk("ack_rst_data", bus.DataOut, 32'd0);
            chk("ack_rst_err", 32'(bus.MisalignErr), 32'd0);
            bus.RAM_enable = 1'b0;
            @(negedge Clk);
            Clr = 1'b1;
            @(negedge Clk);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge Clk);
                chk("mfc_hold", 32'(bus.MFC), 32'd1);
            end
            bus.RAM_enable = 1'b0;
            @(negedge Clk);
            chk("mfc_fall", 32'(bus.MFC), 32'd0);
        end
    endtask

    initial begin : stim
        logic [5:0]  ops [10];
        logic [31:0] pre;
        logic [5:0]  op;
        ops = '{OP_LD, OP_LDUB, OP_LDUH, OP_LDD, OP_ST, OP_STB, OP_STH, OP_STD, OP_LDSB, OP_LDSH};
        bus.RAM_enable = 1'b0;
        bus.RAM_OpCode = '0;
        bus.Address    = '0;
        bus.DataIn     = '0;
        #1;
        chk("rst_mfc", 32'(bus.MFC), 32'd0);
        chk("rst_data", bus.DataOut, 32'd0);
        chk("rst_err", 32'(bus.MisalignErr), 32'd0);
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);

        for (int w = 0; w < 16; w++) req(OP_ST, 32'(w * 4), $urandom, 0, 0);

        req(OP_ST, 32'h10, 32'hDEADBEEF, 0, 0);
        req(OP_LD, 32'h10, 32'h0, 0, 0);
        chk("ld_10", last_data, 32'hDEADBEEF);
        req(OP_STB, 32'h13, 32'h000000A5, 0, 0);
        req(OP_LDSB, 32'h13, 32'h0, 0, 0);
        chk("ldsb_13", last_data, 32'hFFFFFFA5);
        req(OP_LDUB, 32'h13, 32'h0, 0, 0);
        chk("ldub_13", last_data, 32'h000000A5);
        req(OP_LD, 32'h10, 32'h0, 0, 0);
        chk("ld_10_merged", last_data, 32'hDEADBEA5);
        req(OP_LDSH, 32'h12, 32'h0, 0, 0);
        chk("ldsh_12", last_data, 32'hFFFFBEA5);
        req(OP_LDUH, 32'h11, 32'h0, 0, 0);
        chk("lduh_11_err", 32'(last_err), 32'd1);
        chk("lduh_11_data", last_data, 32'd0);
        req(OP_ST, 32'h12, 32'h11223344, 0, 0);
        chk("st_12_err", 32'(last_err), 32'd1);
        req(OP_LD, 32'h10, 32'h0, 5, 0);
        chk("ld_10_after_misalign", last_data, 32'hDEADBEA5);

        // Reset while the store is still waiting: no write may land.
        pre = {ref_mem[32], ref_mem[33], ref_mem[34], ref_mem[35]};
        bus.RAM_OpCode = OP_ST;
        bus.Address    = 32'h20;
        bus.DataIn     = 32'h12345678;
        bus.RAM_enable = 1'b1;
        @(negedge Clk);
        chk("busy_mfc", 32'(bus.MFC), 32'd0);
        Clr = 1'b0;
        #1;
        chk("busy_rst_mfc", 32'(bus.MFC), 32'd0);
        chk("busy_rst_data", bus.DataOut, 32'd0);
        bus.RAM_enable = 1'b0;
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        req(OP_LD, 32'h20, 32'h0, 0, 0);
        chk("ld_20_unwritten", last_data, pre);

        req(OP_LD, 32'h210, 32'h0, 0, 0);
        chk("ld_alias_210", last_data, 32'hDEADBEA5);
        req(OP_LDD, 32'h14, 32'h0, 0, 0);
        chk("ldd_14_err", 32'(last_err), 32'd1);
        req(OP_STD, 32'h18, 32'hCAFEF00D, 0, 0);
        req(OP_LDD, 32'h18, 32'h0, 0, 0);
        chk("ldd_18", last_data, 32'hCAFEF00D);
        req(6'b111111, 32'h10, 32'h0, 0, 0);
        chk("undef_op_err", 32'(last_err), 32'd1);
        req(OP_LD, 32'h10, 32'h0, 0, 1);

        for (int k = 0; k < 150; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            req(op, $urandom & 32'hFFFF_FE3F, $urandom, $urandom_range(0, 3), 0);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
